// File: rtl/stream_hsmooth.sv
// Horizontal 3-tap (1,2,1)/4 smoothing of video rows on a 24-bit RGB valid/ready stream.
// Headers, non-video packets and unfiltered frames are forwarded unchanged.
module stream_hsmooth #(
  parameter logic [10:0] IMAGE_W = 11'd640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        filter_en
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned COL_W = 11;

  typedef enum logic [2:0] {
    WAIT_SOP = 3'd0,
    PASS     = 3'd1,
    FIRST    = 3'd2,
    RUN      = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [PIX_W-1:0]   left;
  logic [PIX_W-1:0]   cur;
  logic               held_eop;

  logic               slot_free;
  logic               accept;
  logic               last_col;
  logic [COL_W-1:0]   col_next;

  // Per channel: (l + 2c + r) >> 2, truncating.
  function automatic logic [PIX_W-1:0] smooth(input logic [PIX_W-1:0] l,
                                               input logic [PIX_W-1:0] c,
                                               input logic [PIX_W-1:0] r);
    logic [PIX_W-1:0] res;
    logic [9:0]       sum;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = 10'(l[ch*8 +: 8]) + 10'({c[ch*8 +: 8], 1'b0}) + 10'(r[ch*8 +: 8]);
      res[ch*8 +: 8] = sum[9:2];
    end
    return res;
  endfunction

  assign slot_free  = ~source_valid | source_ready;
  assign sink_ready = slot_free & (state != FLUSH);
  assign accept     = sink_valid & sink_ready;
  assign last_col   = (col == IMAGE_W - 11'd1);
  assign col_next   = last_col ? '0 : col + 11'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_SOP;
      col          <= '0;
      left         <= '0;
      cur          <= '0;
      held_eop     <= 1'b0;
      source_data  <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else begin
      if (slot_free) source_valid <= 1'b0;

      if (accept) begin
        if (sink_sop) begin
          // A sop restarts packet parsing from any state; held pixels are dropped.
          source_data  <= sink_data;
          source_valid <= 1'b1;
          source_sop   <= 1'b1;
          source_eop   <= sink_eop;
          col          <= '0;
          if (sink_eop)
            state <= WAIT_SOP;
          else if ((sink_data[3:0] == 4'd0) && filter_en)
            state <= FIRST;
          else
            state <= PASS;
        end else begin
          unique case (state)
            FIRST: begin
              left <= sink_data;
              cur  <= sink_data;
              col  <= col_next;
              if (sink_eop || last_col) begin
                state    <= FLUSH;
                held_eop <= sink_eop;
              end else begin
                state <= RUN;
              end
            end
            RUN: begin
              source_data  <= smooth(left, cur, sink_data);
              source_valid <= 1'b1;
              source_sop   <= 1'b0;
              source_eop   <= 1'b0;
              left         <= cur;
              cur          <= sink_data;
              col          <= col_next;
              if (sink_eop || last_col) begin
                state    <= FLUSH;
                held_eop <= sink_eop;
              end
            end
            default: begin
              source_data  <= sink_data;
              source_valid <= 1'b1;
              source_sop   <= 1'b0;
              source_eop   <= sink_eop;
              if ((state == PASS) && sink_eop) state <= WAIT_SOP;
            end
          endcase
        end
      end else if ((state == FLUSH) && slot_free) begin
        // Right edge replicated for the last pixel of the row.
        source_data  <= smooth(left, cur, cur);
        source_valid <= 1'b1;
        source_sop   <= 1'b0;
        source_eop   <= held_eop;
        state        <= held_eop ? WAIT_SOP : FIRST;
      end
    end
  end

endmodule

// File: tb/tb_stream_hsmooth.sv
// Randomised bench for stream_hsmooth (IMAGE_W = 4) against a row-based reference model.
module tb_stream_hsmooth;

  localparam int WI = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        filter_en = 1'b0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        sop;
    logic        eop;
    logic        fen;
    logic [23:0] d;
  } beat_t;

  beat_t       in_q[$];
  beat_t       out_q[$];
  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  logic [31:0] cyc = 0;
  bit          rand_ready = 1'b0;

  stream_hsmooth #(.IMAGE_W(11'(WI))) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .filter_en(filter_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are observed mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (sink_valid && sink_ready)
        in_q.push_back('{cyc: cyc, sop: sink_sop, eop: sink_eop, fen: filter_en, d: sink_data});
      if (source_valid && source_ready)
        out_q.push_back('{cyc: cyc, sop: source_sop, eop: source_eop, fen: 1'b0, d: source_data});
      if (!sink_ready) stall_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_f(input logic [23:0] l, input logic [23:0] c,
                                        input logic [23:0] r);
    logic [23:0] res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int s;
      s = int'(l[8*ch +: 8]) + 2 * int'(c[8*ch +: 8]) + int'(r[8*ch +: 8]);
      res = res | (24'(s / 4) << (8 * ch));
    end
    return res;
  endfunction

  // Expected output: header as-is; filtered packets split into rows of WI with edge replication.
  task automatic build_expected();
    int i = 0;
    exp_q.delete();
    while (i < in_q.size()) begin
      beat_t       h;
      logic [23:0] pix[$];
      bit          filt;
      int          n;
      h = in_q[i];
      i++;
      exp_q.push_back('{cyc: 0, sop: h.sop, eop: h.eop, fen: 1'b0, d: h.d});
      if (h.eop) continue;
      filt = (h.d[3:0] == 4'd0) && h.fen;
      pix.delete();
      while (i < in_q.size()) begin
        pix.push_back(in_q[i].d);
        i++;
        if (in_q[i-1].eop) break;
      end
      n = pix.size();
      for (int k = 0; k < n; k++) begin
        int row0, rend, kl, kr;
        logic [23:0] d;
        row0 = (k / WI) * WI;
        rend = (row0 + WI - 1 < n - 1) ? row0 + WI - 1 : n - 1;
        kl = (k == row0) ? k : k - 1;
        kr = (k == rend) ? k : k + 1;
        d = filt ? ref_f(pix[kl], pix[k], pix[kr]) : pix[k];
        exp_q.push_back('{cyc: 0, sop: 1'b0, eop: (k == n - 1), fen: 1'b0, d: d});
      end
    end
  endtask

  task automatic compare_model(input string name);
    int m;
    build_expected();
    check({name, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    m = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int k = 0; k < m; k++)
      check($sformatf("%s_beat%0d", name, k),
            32'({out_q[k].sop, out_q[k].eop, out_q[k].d}),
            32'({exp_q[k].sop, exp_q[k].eop, exp_q[k].d}));
  endtask

  task automatic clear_q();
    in_q.delete();
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop, input bit gap);
    int guard = 0;
    bit ok;
    if (gap && ($urandom_range(0, 2) == 0)) begin
      sink_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    sink_data  = d;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = sink_ready;
      if (!ok) guard++;
      @(posedge clk);
      #1;
    end while (!ok && guard < 1000);
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic send_packet(input logic [23:0] hdr, input logic fen, input logic [23:0] pix[$],
                             input bit gap, input bit fen_flip);
    filter_en = fen;
    send_beat(hdr, 1'b1, (pix.size() == 0), gap);
    if (fen_flip) filter_en = ~fen;
    for (int k = 0; k < pix.size(); k++)
      send_beat(pix[k], 1'b0, (k == pix.size() - 1), gap);
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] pix[$];
    logic [23:0] hdr;
    int          eops;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(source_valid), 32'd0);
    check("rst_sink_ready", 32'(sink_ready), 32'd1);
    check("rst_data", 32'(source_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_beat(24'h000000, 1'b1, 1'b1, 1'b0);
    check("first_valid", 32'(source_valid), 32'd1);
    check("first_sop_eop", 32'({source_sop, source_eop}), 32'b11);
    check("first_data", 32'(source_data), 32'd0);
    drain();
    clear_q();

    // Single filtered row R = 0,40,80,120
    stall_cnt = 0;
    pix = '{24'h000000, 24'h280000, 24'h500000, 24'h780000};
    send_packet(24'h000000, 1'b1, pix, 1'b0, 1'b0);
    drain();
    compare_model("row");
    exp_q = '{'{cyc: 0, sop: 1'b1, eop: 1'b0, fen: 1'b0, d: 24'h000000},
              '{cyc: 0, sop: 1'b0, eop: 1'b0, fen: 1'b0, d: 24'h0A0000},
              '{cyc: 0, sop: 1'b0, eop: 1'b0, fen: 1'b0, d: 24'h280000},
              '{cyc: 0, sop: 1'b0, eop: 1'b0, fen: 1'b0, d: 24'h500000},
              '{cyc: 0, sop: 1'b0, eop: 1'b1, fen: 1'b0, d: 24'h6E0000}};
    for (int k = 0; k < out_q.size() && k < 5; k++)
      check($sformatf("row_const%0d", k), 32'({out_q[k].sop, out_q[k].eop, out_q[k].d}),
            32'({exp_q[k].sop, exp_q[k].eop, exp_q[k].d}));
    check("row_bubble", 32'(stall_cnt), 32'd1);
    clear_q();

    // Non-video header: passthrough with 1-cycle latency and no bubbles
    stall_cnt = 0;
    pix = '{24'h123456, 24'h123456, 24'h123456};
    send_packet(24'h00000F, 1'b1, pix, 1'b0, 1'b0);
    drain();
    compare_model("pass");
    for (int k = 0; k < in_q.size() && k < out_q.size(); k++)
      check($sformatf("pass_lat%0d", k), out_q[k].cyc - in_q[k].cyc, 32'd1);
    check("pass_bubble", 32'(stall_cnt), 32'd0);
    clear_q();

    // filter_en low at sop, raised mid-packet
    pix = '{};
    for (int k = 0; k < 5; k++) pix.push_back(24'($urandom));
    send_packet(24'h000010, 1'b0, pix, 1'b0, 1'b1);
    drain();
    compare_model("en_mid");
    for (int k = 1; k < out_q.size() && k < 6; k++)
      check($sformatf("en_mid_raw%0d", k), 32'(out_q[k].d), 32'(pix[k-1]));
    clear_q();

    // Two-row frame under random backpressure
    pix = '{};
    for (int k = 0; k < 8; k++) pix.push_back(24'($urandom));
    rand_ready = 1'b1;
    send_packet(24'h000000, 1'b1, pix, 1'b1, 1'b0);
    drain();
    compare_model("frame2");
    eops = 0;
    foreach (out_q[k]) if (out_q[k].eop) eops++;
    check("frame2_eops", 32'(eops), 32'd1);
    check("frame2_last_eop", 32'(out_q.size() > 0 ? out_q[out_q.size()-1].eop : 1'b0), 32'd1);
    clear_q();

    // Random mix of packets
    rand_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      hdr = 24'($urandom);
      if ($urandom_range(0, 1) == 1) hdr[3:0] = 4'd0;
      pix = '{};
      for (int k = 0; k < int'($urandom_range(0, 11)); k++) pix.push_back(24'($urandom));
      rand_ready = 1'b1;
      send_packet(hdr, 1'($urandom_range(0, 1)), pix, 1'b1, 1'($urandom_range(0, 1)));
    end
    drain();
    compare_model("rand");
    clear_q();

    // Single-pixel video packet
    pix = '{24'h808080};
    send_packet(24'h000000, 1'b1, pix, 1'b0, 1'b0);
    drain();
    compare_model("one_pix");
    check("one_pix_out", 32'(out_q.size() > 1 ? {out_q[1].eop, out_q[1].d} : 25'd0),
          32'({1'b1, 24'h808080}));
    clear_q();

    // Reset mid-packet
    filter_en = 1'b1;
    send_beat(24'h000000, 1'b1, 1'b0, 1'b0);
    send_beat(24'h102030, 1'b0, 1'b0, 1'b0);
    send_beat(24'h405060, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(source_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(source_valid), 32'd0);
    check("rst_mid_data", 32'(source_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
    check("post_rst_ready", 32'(sink_ready), 32'd1);
    pix = '{};
    for (int k = 0; k < 6; k++) pix.push_back(24'($urandom));
    rand_ready = 1'b1;
    send_packet(24'h000000, 1'b1, pix, 1'b1, 1'b0);
    drain();
    compare_model("post_rst");
    clear_q();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
